// File: rtl/asip_ex_pkg.sv
// asip_ex_pkg: shared types and helpers for the ASIP execute stage.
//   DATA_W     - datapath width
//   CNT_W      - width of the modular-multiply bit counter
//   alu_func_e - ALU function encoding carried in alu_func_ex
//   mm_state_e - modular-multiply sequencer states
//   fwd_sel_e  - operand forwarding source
//   fwd_select - forwarding source for one operand; MEM wins over WB, r0 never forwards
package asip_ex_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    MODMUL = 2'b10,
    SETMOD = 2'b11
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mm_state_e;

  typedef enum logic [1:0] {
    REG = 2'b00,
    MEM = 2'b01,
    WB  = 2'b10
  } fwd_sel_e;

  function automatic fwd_sel_e fwd_select(input logic [4:0] idx,
                                          input logic [4:0] rw_mem,
                                          input logic       wr_en_mem,
                                          input logic [4:0] rw_wb,
                                          input logic       wr_en_wb);
    fwd_sel_e sel;
    sel = REG;
    if (idx != 5'd0) begin
      if (wr_en_mem && (rw_mem == idx)) begin
        sel = MEM;
      end else if (wr_en_wb && (rw_wb == idx)) begin
        sel = WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mod_mul_iter.sv
// mod_mul_iter: iterative (a*b) mod m, interleaved shift-add, MSB of b first.
//   clock, reset - pipeline clock, synchronous active-high reset
//   start        - begin an operation (sampled only in IDLE)
//   a, b, m      - operands, latched on the start edge
//   busy         - high in the start cycle and all BUSY cycles
//   done         - high for the single cycle in which p is the result
//   p            - current partial product (the result while done=1)
module mod_mul_iter
  import asip_ex_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] p
);

  localparam int CW = $clog2(N);

  mm_state_e    state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [N+1:0] p_q, p_d;
  logic [CW-1:0] count_q, count_d;

  logic [N+1:0] m_ext, p_dbl, p_add, p_sub1, p_step;

  // One reduction step. With a < m the sum 2P + a stays below 3m, so two
  // conditional subtractions bring it back under m. A zero modulus would make
  // the subtractions no-ops, so the product is pinned to zero instead.
  always_comb begin
    m_ext  = {2'b00, m_q};
    p_dbl  = p_q << 1;
    p_add  = b_q[count_q] ? (p_dbl + {2'b00, a_q}) : p_dbl;
    p_sub1 = (p_add >= m_ext) ? (p_add - m_ext) : p_add;
    p_step = (p_sub1 >= m_ext) ? (p_sub1 - m_ext) : p_sub1;
    if (m_q == '0) begin
      p_step = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      count_q <= count_d;
    end
  end

  // Operands are captured once at start so forwarding changes during BUSY
  // cannot disturb the running product.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          p_d     = '0;
          count_d = CW'(N - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        p_d = p_step;
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == BUSY) || ((state_q == IDLE) && start);
  assign done = (state_q == DONE);
  assign p    = p_q[N-1:0];

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RSA-decryption ASIP pipeline.
//   clock, reset                  - pipeline clock, synchronous active-high reset
//   rda_ex, rdb_ex, extended_ex   - register operands and immediate from ID/EX
//   ra_ex, rb_ex, rw_ex           - source/destination register indices
//   wr_en_ex, wm_ex, wd_selector_ex, opb_selector_ex, alu_func_ex - decoded controls
//   rw_mem/wb, wr_en_mem/wb, result_mem/wb - forwarding sources
//   alu_result, store_data, rw_out, wr_en_out, wm_out, wd_selector_out - to EX/MEM
//   stall                         - holds PC, IF/ID and ID/EX during MODMUL
module ex_stage
  import asip_ex_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] rda_ex,
  input  logic [N-1:0] rdb_ex,
  input  logic [N-1:0] extended_ex,
  input  logic [4:0]   ra_ex,
  input  logic [4:0]   rb_ex,
  input  logic [4:0]   rw_ex,
  input  logic         wr_en_ex,
  input  logic         wm_ex,
  input  logic         wd_selector_ex,
  input  logic         opb_selector_ex,
  input  logic [1:0]   alu_func_ex,
  input  logic [4:0]   rw_mem,
  input  logic [4:0]   rw_wb,
  input  logic         wr_en_mem,
  input  logic         wr_en_wb,
  input  logic [N-1:0] result_mem,
  input  logic [N-1:0] result_wb,
  output logic [N-1:0] alu_result,
  output logic [N-1:0] store_data,
  output logic [4:0]   rw_out,
  output logic         wr_en_out,
  output logic         wm_out,
  output logic         wd_selector_out,
  output logic         stall
);

  alu_func_e    func;
  logic [N-1:0] fwd_a, fwd_b, op_b, mod_q, mm_p, alu_raw;
  logic         mm_start, mm_busy, mm_done, stall_int;

  assign func = alu_func_e'(alu_func_ex);

  always_comb begin
    unique case (fwd_select(ra_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb))
      MEM:     fwd_a = result_mem;
      WB:      fwd_a = result_wb;
      default: fwd_a = rda_ex;
    endcase
  end

  always_comb begin
    unique case (fwd_select(rb_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb))
      MEM:     fwd_b = result_mem;
      WB:      fwd_b = result_wb;
      default: fwd_b = rdb_ex;
    endcase
  end

  assign op_b     = opb_selector_ex ? extended_ex : fwd_b;
  assign mm_start = (func == MODMUL) && !reset;

  mod_mul_iter #(.N(N)) u_mod_mul (
    .clock (clock),
    .reset (reset),
    .start (mm_start),
    .a     (fwd_a),
    .b     (op_b),
    .m     (mod_q),
    .busy  (mm_busy),
    .done  (mm_done),
    .p     (mm_p)
  );

  // Modulus register; a MODMUL issued right after SETMOD sees the new value
  // because the multiplier latches m on the following edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      mod_q <= '0;
    end else if (func == SETMOD) begin
      mod_q <= fwd_a;
    end
  end

  always_comb begin
    alu_raw = '0;
    unique case (func)
      ADD:     alu_raw = fwd_a + op_b;
      SUB:     alu_raw = fwd_a - op_b;
      SETMOD:  alu_raw = fwd_a;
      MODMUL:  alu_raw = mm_done ? mm_p : '0;
      default: alu_raw = '0;
    endcase
  end

  // While stalled the EX/MEM register must latch a bubble, so the write
  // enables and result are squashed; reset zeroes every output.
  assign stall_int       = mm_busy && !reset;
  assign stall           = stall_int;
  assign alu_result      = (reset || stall_int) ? '0 : alu_raw;
  assign store_data      = reset ? '0 : fwd_b;
  assign rw_out          = reset ? 5'd0 : rw_ex;
  assign wr_en_out       = wr_en_ex && !reset && !stall_int;
  assign wm_out          = wm_ex && !reset && !stall_int;
  assign wd_selector_out = wd_selector_ex && !reset;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clock;
  logic        reset;
  logic [31:0] rda_ex, rdb_ex, extended_ex;
  logic [4:0]  ra_ex, rb_ex, rw_ex;
  logic        wr_en_ex, wm_ex, wd_selector_ex, opb_selector_ex;
  logic [1:0]  alu_func_ex;
  logic [4:0]  rw_mem, rw_wb;
  logic        wr_en_mem, wr_en_wb;
  logic [31:0] result_mem, result_wb;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rw_out;
  logic        wr_en_out, wm_out, wd_selector_out, stall;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] F_ADD = 2'b00, F_SUB = 2'b01, F_MODMUL = 2'b10, F_SETMOD = 2'b11;

  ex_stage dut (
    .clock           (clock),
    .reset           (reset),
    .rda_ex          (rda_ex),
    .rdb_ex          (rdb_ex),
    .extended_ex     (extended_ex),
    .ra_ex           (ra_ex),
    .rb_ex           (rb_ex),
    .rw_ex           (rw_ex),
    .wr_en_ex        (wr_en_ex),
    .wm_ex           (wm_ex),
    .wd_selector_ex  (wd_selector_ex),
    .opb_selector_ex (opb_selector_ex),
    .alu_func_ex     (alu_func_ex),
    .rw_mem          (rw_mem),
    .rw_wb           (rw_wb),
    .wr_en_mem       (wr_en_mem),
    .wr_en_wb        (wr_en_wb),
    .result_mem      (result_mem),
    .result_wb       (result_wb),
    .alu_result      (alu_result),
    .store_data      (store_data),
    .rw_out          (rw_out),
    .wr_en_out       (wr_en_out),
    .wm_out          (wm_out),
    .wd_selector_out (wd_selector_out),
    .stall           (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] func, input logic [4:0] ra, input logic [31:0] rda,
                               input logic [4:0] rb, input logic [31:0] rdb,
                               input logic opb_sel, input logic [31:0] ext);
    alu_func_ex     = func;
    ra_ex           = ra;
    rda_ex          = rda;
    rb_ex           = rb;
    rdb_ex          = rdb;
    opb_selector_ex = opb_sel;
    extended_ex     = ext;
    #1;
  endtask

  task automatic clear_fwd();
    wr_en_mem  = 1'b0;
    wr_en_wb   = 1'b0;
    rw_mem     = 5'd0;
    rw_wb      = 5'd0;
    result_mem = 32'h0;
    result_wb  = 32'h0;
  endtask

  // Runs a MODMUL already presented on the inputs until stall drops (bounded),
  // optionally changing result_mem partway through BUSY.
  task automatic measure_modmul(input bit poke_mem, input logic [31:0] poke_val,
                                output int cycles, output bit leak,
                                output logic [31:0] res, output logic stall_end,
                                output logic wen_end);
    cycles = 0;
    leak   = 1'b0;
    while (stall === 1'b1 && cycles < 40) begin
      if (wr_en_out !== 1'b0 || wm_out !== 1'b0 || alu_result !== 32'h0) leak = 1'b1;
      cycles++;
      step();
      if (poke_mem && cycles == 5) begin
        result_mem = poke_val;
        #1;
      end
    end
    res       = alu_result;
    stall_end = stall;
    wen_end   = wr_en_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en_ex = 1'b1; wm_ex = 1'b1; wd_selector_ex = 1'b1; rw_ex = 5'd7;
    applyStimulus(F_MODMUL, 5'd1, 32'h55, 5'd2, 32'h66, 1'b0, 32'h0);
    step();
    step();
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    compared++; if (alu_result !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_alu_result: got %h expected 0", alu_result); end
    compared++; if (store_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_store_data: got %h expected 0", store_data); end
    compared++; if (rw_out !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rw_out: got %0d expected 0", rw_out); end
    compared++; if ({wr_en_out, wm_out, wd_selector_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_controls: got %b expected 000", {wr_en_out, wm_out, wd_selector_out}); end
    applyStimulus(F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_forwarding();
    wr_en_ex = 1'b1; wm_ex = 1'b0; wd_selector_ex = 1'b1; rw_ex = 5'd9;
    rw_mem = 5'd5; rw_wb = 5'd5; wr_en_mem = 1'b1; wr_en_wb = 1'b1;
    result_mem = 32'h10; result_wb = 32'h20;
    applyStimulus(F_ADD, 5'd5, 32'h30, 5'd5, 32'h40, 1'b1, 32'h1);
    compared++; if (alu_result !== 32'h11) begin mismatched++; $display("[TB] FAIL fwd_mem_priority: got %h expected 11", alu_result); end
    compared++; if (store_data !== 32'h10) begin mismatched++; $display("[TB] FAIL fwd_store_data: got %h expected 10", store_data); end
    compared++; if (rw_out !== 5'd9 || wr_en_out !== 1'b1 || wd_selector_out !== 1'b1) begin mismatched++; $display("[TB] FAIL passthrough: rw_out=%0d wr_en_out=%b wd_sel=%b expected 9/1/1", rw_out, wr_en_out, wd_selector_out); end
    wr_en_mem = 1'b0;
    #1;
    compared++; if (alu_result !== 32'h21) begin mismatched++; $display("[TB] FAIL fwd_wb: got %h expected 21", alu_result); end
    wr_en_mem = 1'b1; rw_mem = 5'd0; rw_wb = 5'd0;
    applyStimulus(F_ADD, 5'd0, 32'h30, 5'd0, 32'h40, 1'b1, 32'h1);
    compared++; if (alu_result !== 32'h31) begin mismatched++; $display("[TB] FAIL fwd_r0: got %h expected 31", alu_result); end
    clear_fwd();
    step();
  endtask

  task automatic test_sub();
    applyStimulus(F_SUB, 5'd1, 32'h5, 5'd2, 32'h0, 1'b1, 32'hFFFF_FFFF);
    compared++; if (alu_result !== 32'h6) begin mismatched++; $display("[TB] FAIL sub_imm: got %h expected 6", alu_result); end
    applyStimulus(F_SUB, 5'd1, 32'h0, 5'd2, 32'h1, 1'b0, 32'h0);
    compared++; if (alu_result !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL sub_wrap: got %h expected ffffffff", alu_result); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL sub_no_stall: got %b expected 0", stall); end
    step();
  endtask

  task automatic test_modmul_13();
    int cyc; bit leak; logic [31:0] res; logic st, we;
    wr_en_ex = 1'b1; wm_ex = 1'b1;
    applyStimulus(F_SETMOD, 5'd1, 32'd13, 5'd0, 32'h0, 1'b0, 32'h0);
    compared++; if (alu_result !== 32'd13 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL setmod_13: alu_result=%h stall=%b expected d/0", alu_result, stall); end
    step();
    rw_mem = 5'd3; wr_en_mem = 1'b1; result_mem = 32'd7;
    applyStimulus(F_MODMUL, 5'd3, 32'h0, 5'd4, 32'd11, 1'b0, 32'h0);
    measure_modmul(1'b1, 32'd9, cyc, leak, res, st, we);
    compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL mm13_stall_cycles: got %0d expected 33", cyc); end
    compared++; if (res !== 32'd12) begin mismatched++; $display("[TB] FAIL mm13_result: got %0d expected 12", res); end
    compared++; if (st !== 1'b0 || we !== 1'b1) begin mismatched++; $display("[TB] FAIL mm13_done_controls: stall=%b wr_en_out=%b expected 0/1", st, we); end
    compared++; if (leak !== 1'b0) begin mismatched++; $display("[TB] FAIL mm13_bubble: leak=%b expected 0", leak); end
    clear_fwd();
    wm_ex = 1'b0;
    step();
    applyStimulus(F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_modmul_zero_m();
    int cyc; bit leak; logic [31:0] res; logic st, we;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rw_mem = 5'd2; wr_en_mem = 1'b1; result_mem = 32'd5;
    applyStimulus(F_MODMUL, 5'd2, 32'h0, 5'd0, 32'h0, 1'b1, 32'd6);
    measure_modmul(1'b1, 32'h1234, cyc, leak, res, st, we);
    compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL mm0_stall_cycles: got %0d expected 33", cyc); end
    compared++; if (res !== 32'd0) begin mismatched++; $display("[TB] FAIL mm0_result: got %h expected 0", res); end
    clear_fwd();
    step();
    applyStimulus(F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_reset_abort();
    int cyc; bit leak; logic [31:0] res; logic st, we;
    applyStimulus(F_SETMOD, 5'd1, 32'd13, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(F_MODMUL, 5'd1, 32'd7, 5'd0, 32'h0, 1'b1, 32'd11);
    for (int i = 0; i < 10; i++) step();
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_busy_stall: got %b expected 1", stall); end
    reset = 1'b1;
    step();
    compared++; if (stall !== 1'b0 || alu_result !== 32'h0 || store_data !== 32'h0) begin mismatched++; $display("[TB] FAIL abort_outputs: stall=%b alu_result=%h store_data=%h expected 0/0/0", stall, alu_result, store_data); end
    compared++; if ({wr_en_out, wm_out, wd_selector_out} !== 3'b000 || rw_out !== 5'd0) begin mismatched++; $display("[TB] FAIL abort_controls: ctl=%b rw_out=%0d expected 000/0", {wr_en_out, wm_out, wd_selector_out}, rw_out); end
    reset = 1'b0;
    applyStimulus(F_MODMUL, 5'd1, 32'd3, 5'd0, 32'h0, 1'b1, 32'd4);
    measure_modmul(1'b0, 32'h0, cyc, leak, res, st, we);
    compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL abort_mm_cycles: got %0d expected 33", cyc); end
    compared++; if (res !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_mm_cleared_m: got %h expected 0", res); end
    step();
    applyStimulus(F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  task automatic test_back_to_back();
    int cyc; bit leak; logic [31:0] res; logic st, we;
    longint unsigned prod;
    logic [31:0] expv;
    prod = 64'h1234_5678 * 64'h9ABC_DEF0;
    expv = 32'(prod % 64'hFFFF_FFFB);
    applyStimulus(F_SETMOD, 5'd1, 32'hFFFF_FFFB, 5'd0, 32'h0, 1'b0, 32'h0);
    compared++; if (alu_result !== 32'hFFFF_FFFB) begin mismatched++; $display("[TB] FAIL b2b_setmod: got %h expected fffffffb", alu_result); end
    step();
    applyStimulus(F_MODMUL, 5'd1, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 32'h9ABC_DEF0);
    measure_modmul(1'b0, 32'h0, cyc, leak, res, st, we);
    compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL b2b_mm1_cycles: got %0d expected 33", cyc); end
    compared++; if (res !== expv) begin mismatched++; $display("[TB] FAIL b2b_mm1_result: got %h expected %h", res, expv); end
    step();
    applyStimulus(F_MODMUL, 5'd1, 32'd2, 5'd0, 32'h0, 1'b1, 32'd3);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_mm2_start: stall=%b expected 1", stall); end
    measure_modmul(1'b0, 32'h0, cyc, leak, res, st, we);
    compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL b2b_mm2_cycles: got %0d expected 33", cyc); end
    compared++; if (res !== 32'd6) begin mismatched++; $display("[TB] FAIL b2b_mm2_result: got %h expected 6", res); end
    step();
    applyStimulus(F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    rda_ex = '0; rdb_ex = '0; extended_ex = '0;
    ra_ex = '0; rb_ex = '0; rw_ex = '0;
    wr_en_ex = 1'b0; wm_ex = 1'b0; wd_selector_ex = 1'b0; opb_selector_ex = 1'b0;
    alu_func_ex = F_ADD;
    clear_fwd();
    $display("[TB] starting ex_stage bench");
    test_reset();
    test_forwarding();
    test_sub();
    test_modmul_13();
    test_modmul_zero_m();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
